pieo_post_deq_shaper: RTL and testbench
=======================================

PIEO_POST_DEQ_SHAPER -- requirements
Module: pieo_post_deq_shaper

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- PKT_LEN_WIDTH, 16, packet length width in bytes.
- TB_SCALE, 4, fractional token bits.
- NUM_QUEUES, 8, queue count.
- ID_LOG, $clog2(NUM_QUEUES), queue-id width.
- RANK_LOG, 1, rank field width.
- TIME_LOG, 1, time field width.
- REFILL_DIV, 16, cycles per shaping refill tick (>=1).
- MAX_PKTS, 0, packets per turn (0 = unlimited).
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- en_in, in, 1, scheduler enable.
- deq_valid, in, 1, PIEO element valid.
- deq_element, in, ID_LOG+RANK_LOG+TIME_LOG, element; id in bits [ID_LOG-1:0].
- post_deq_ready, out, 1, ready to accept element.
- fifo_tvalid, in, NUM_QUEUES, queue non-empty.
- pe_tlast, in, NUM_QUEUES, last beat of packet.
- fifo_packet_length, in, NUM_QUEUES*PKT_LEN_WIDTH, head packet length.
- fifo_drr_quantum, in, NUM_QUEUES*PKT_LEN_WIDTH, DRR quantum.
- fifo_max_burst, in, NUM_QUEUES*PKT_LEN_WIDTH, token cap.
- fifo_enable_shaping, in, NUM_QUEUES, shaping mode per queue.
- fifo_max_rate, in, NUM_QUEUES*PKT_LEN_WIDTH, tokens per refill tick.
- tb_fifo_eligible, out, NUM_QUEUES, queue may be enqueued to PIEO.
- post_deq_end, out, NUM_QUEUES, one-cycle turn-end pulse.
- sel_out, out, ID_LOG, mux select.
- en_out, out, 1, mux enable.

Function
REQ-003 Token buckets SHALL be signed, TB_WIDTH+1 bits, where TB_WIDTH = PKT_LEN_WIDTH+TB_SCALE; all length/quantum/burst operands SHALL be left-shifted by TB_SCALE.
REQ-004 The refill prescaler SHALL count 0..REFILL_DIV-1 and wrap; on wrap, every shaped queue SHALL add fifo_max_rate.
REQ-005 Bucket update SHALL be next = tb + inc - dec, evaluated in one cycle.
- The result SHALL saturate high at fifo_max_burst<<TB_SCALE.
- The result SHALL saturate low at the most negative representable value.
- Simultaneous refill, grant and decrement SHALL all apply in the same cycle.
REQ-006 tb_fifo_eligible[i] SHALL be combinational: ~shaping[i] | (tb[i]>>>TB_SCALE) >= packet_length[i].
REQ-007 The FSM SHALL have the states IDLE, SEND and CHECK.
- post_deq_ready SHALL equal (state==IDLE).
REQ-008 IDLE: when en_in & deq_valid, the element SHALL be accepted.
- If id >= NUM_QUEUES, the element SHALL be dropped with no other effect.
- Otherwise: latch sel; zero the packet counter; go to SEND; drive en_out=1 from the next cycle.
- An unshaped queue SHALL receive +quantum on acceptance.
REQ-009 SEND, on pe_tlast[sel]: subtract the length, increment the packet counter, and deassert en_out next cycle.
- The turn SHALL end if tb+inc-dec <= 0, or the packet counter reaches MAX_PKTS (MAX_PKTS != 0), or ~en_in.
- Otherwise the FSM SHALL go to CHECK.
REQ-010 CHECK: if fifo_tvalid[sel], the FSM SHALL return to SEND with en_out=1 next cycle; else the turn ends.
REQ-011 Turn end SHALL return to IDLE and pulse post_deq_end[sel] for exactly one cycle, registered with the state change.
- An unshaped queue that ends because it is empty or because of ~en_in SHALL have its bucket cleared to 0.
- An unshaped queue that ends on exhaustion or MAX_PKTS SHALL retain its deficit.
REQ-012 sel_out and en_out SHALL be registered; sel_out SHALL hold its last value while in IDLE.
REQ-013 pe_tlast on a non-selected queue SHALL be ignored.

Reset
REQ-014 While rst_n=0, the block SHALL hold: all buckets 0, prescaler 0, state IDLE, sel_out 0, en_out 0, post_deq_end 0, packet counter 0.
REQ-015 Reset assertion mid-turn SHALL abort immediately with no post_deq_end pulse.
REQ-016 After reset release, post_deq_ready SHALL be 1 in the first cycle.

Structure
REQ-017 A shared package pieo_sched_pkg SHALL hold the FSM state enum and the TB_WIDTH derivation.
REQ-018 The per-queue bucket arithmetic (REQ-005, REQ-006) SHALL be a sub-module pieo_token_bucket, instantiated NUM_QUEUES times via generate.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Unshaped q2, quantum 1500, three 600 B packets: send 600, 600 (tb=300), then 600 (tb -> -300); post_deq_end[2] pulses; deficit -300 is retained.
- Shaped q1, rate 100, REFILL_DIV 16, burst 2000: after 400 cycles, tb = 2000<<4 (saturated); eligible for a 1500 B packet.
- MAX_PKTS=2, unshaped quantum 9000, four 64 B packets: the turn ends after 2 packets; tb = 9000-128 is retained.
- Queue empties after 1 packet (fifo_tvalid=0 in CHECK): post_deq_end pulses; unshaped bucket becomes 0.
- deq id = NUM_QUEUES: accepted and dropped; state stays IDLE; en_out stays 0.
- rst_n low during SEND: en_out is 0 asynchronously; no end pulse; post_deq_ready is 1 after release.

Source files
------------

// File: rtl/pieo_sched_pkg.sv
// Shared scheduler definitions: turn FSM states and token-bucket width derivation.
package pieo_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StCheck = 2'd2
  } state_e;

  // Integer part (packet length bytes) plus fractional token bits.
  function automatic int unsigned tb_width(input int unsigned pkt_len_width,
                                           input int unsigned tb_scale);
    return pkt_len_width + tb_scale;
  endfunction

endpackage

// File: rtl/pieo_token_bucket.sv
// Per-queue signed token bucket: single-cycle add/subtract with saturation and eligibility.
module pieo_token_bucket
  import pieo_sched_pkg::*;
#(
  parameter int unsigned PKT_LEN_WIDTH = 16,
  parameter int unsigned TB_SCALE      = 4,
  localparam int unsigned TB_WIDTH     = tb_width(PKT_LEN_WIDTH, TB_SCALE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shaping,
  input  logic                       refill,
  input  logic                       grant,
  input  logic                       consume,
  input  logic                       clear,
  input  logic [PKT_LEN_WIDTH-1:0]   max_rate,
  input  logic [PKT_LEN_WIDTH-1:0]   quantum,
  input  logic [PKT_LEN_WIDTH-1:0]   max_burst,
  input  logic [PKT_LEN_WIDTH-1:0]   pkt_len,
  output logic signed [TB_WIDTH:0]   tb_next,
  output logic                       eligible
);

  // Three guard bits cover bucket + refill + quantum without overflow.
  localparam int unsigned SumW = TB_WIDTH + 3;

  // Rate is expressed in bytes per tick, so it is scaled like the other byte operands.
  function automatic logic signed [SumW-1:0] scale(input logic [PKT_LEN_WIDTH-1:0] v);
    return $signed({3'b000, v, {TB_SCALE{1'b0}}});
  endfunction

  logic signed [TB_WIDTH:0] tb_q;
  logic signed [TB_WIDTH:0] tb_tokens;
  logic signed [SumW-1:0]   inc, dec, sum, cap, floor_v;

  always_comb begin
    inc = '0;
    if (refill && shaping) inc = inc + scale(max_rate);
    if (grant) inc = inc + scale(quantum);
    dec     = consume ? scale(pkt_len) : '0;
    cap     = scale(max_burst);
    floor_v = $signed({{3{1'b1}}, {TB_WIDTH{1'b0}}});
    sum     = $signed({{2{tb_q[TB_WIDTH]}}, tb_q}) + inc - dec;
    if (sum > cap) begin
      tb_next = cap[TB_WIDTH:0];
    end else if (sum < floor_v) begin
      tb_next = floor_v[TB_WIDTH:0];
    end else begin
      tb_next = sum[TB_WIDTH:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_q <= '0;
    end else if (clear) begin
      tb_q <= '0;
    end else begin
      tb_q <= tb_next;
    end
  end

  assign tb_tokens = tb_q >>> TB_SCALE;
  assign eligible  = ~shaping | (tb_tokens >= $signed({{(TB_SCALE+1){1'b0}}, pkt_len}));

endmodule

// File: rtl/pieo_post_deq_shaper.sv
// Post-dequeue DRR/shaping stage: serves one PIEO-selected queue per turn and
// tracks per-queue deficit or rate tokens.
module pieo_post_deq_shaper
  import pieo_sched_pkg::*;
#(
  parameter int unsigned PKT_LEN_WIDTH = 16,
  parameter int unsigned TB_SCALE      = 4,
  parameter int unsigned NUM_QUEUES    = 8,
  parameter int unsigned ID_LOG        = $clog2(NUM_QUEUES),
  parameter int unsigned RANK_LOG      = 1,
  parameter int unsigned TIME_LOG      = 1,
  parameter int unsigned REFILL_DIV    = 16,
  parameter int unsigned MAX_PKTS      = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en_in,
  input  logic                                deq_valid,
  input  logic [ID_LOG+RANK_LOG+TIME_LOG-1:0] deq_element,
  output logic                                post_deq_ready,
  input  logic [NUM_QUEUES-1:0]               fifo_tvalid,
  input  logic [NUM_QUEUES-1:0]               pe_tlast,
  input  logic [NUM_QUEUES*PKT_LEN_WIDTH-1:0] fifo_packet_length,
  input  logic [NUM_QUEUES*PKT_LEN_WIDTH-1:0] fifo_drr_quantum,
  input  logic [NUM_QUEUES*PKT_LEN_WIDTH-1:0] fifo_max_burst,
  input  logic [NUM_QUEUES-1:0]               fifo_enable_shaping,
  input  logic [NUM_QUEUES*PKT_LEN_WIDTH-1:0] fifo_max_rate,
  output logic [NUM_QUEUES-1:0]               tb_fifo_eligible,
  output logic [NUM_QUEUES-1:0]               post_deq_end,
  output logic [ID_LOG-1:0]                   sel_out,
  output logic                                en_out
);

  localparam int unsigned TB_WIDTH = tb_width(PKT_LEN_WIDTH, TB_SCALE);
  localparam int unsigned DivW     = (REFILL_DIV > 1) ? $clog2(REFILL_DIV) : 1;
  localparam int unsigned CntW     = 16;

  state_e                   state_q, state_d;
  logic [ID_LOG-1:0]        sel_q, sel_d, deq_id;
  logic                     en_q;
  logic [NUM_QUEUES-1:0]    end_q, end_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [DivW-1:0]          div_q;
  logic                     refill, id_ok, accept_ok, turn_end, clr_sel, exhausted, max_hit;
  logic                     tlast_sel, tvalid_sel;
  logic [NUM_QUEUES-1:0]    sel_hot, grant, consume, clear;
  logic signed [TB_WIDTH:0] tb_next [NUM_QUEUES];
  logic signed [TB_WIDTH:0] tb_sel;
  logic                     unused_elem;

  assign deq_id      = deq_element[ID_LOG-1:0];
  assign unused_elem = ^deq_element[ID_LOG+RANK_LOG+TIME_LOG-1:ID_LOG];
  assign id_ok       = 32'(deq_id) < NUM_QUEUES;
  assign accept_ok   = (state_q == StIdle) && en_in && deq_valid && id_ok;
  assign refill      = (div_q == DivW'(REFILL_DIV - 1));

  always_comb begin
    sel_hot = '0;
    tb_sel  = '0;
    grant   = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (sel_q == ID_LOG'(i)) begin
        sel_hot[i] = 1'b1;
        tb_sel     = tb_next[i];
      end
      grant[i] = accept_ok && (deq_id == ID_LOG'(i)) && !fifo_enable_shaping[i];
    end
  end

  assign tlast_sel  = |(pe_tlast & sel_hot);
  assign tvalid_sel = |(fifo_tvalid & sel_hot);
  assign consume    = (state_q == StSend) ? (pe_tlast & sel_hot) : '0;
  assign clear      = clr_sel ? (sel_hot & ~fifo_enable_shaping) : '0;
  assign exhausted  = tb_sel[TB_WIDTH] | (tb_sel == '0);
  assign max_hit    = (MAX_PKTS != 0) && (cnt_d == CntW'(MAX_PKTS));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    end_d    = '0;
    turn_end = 1'b0;
    clr_sel  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept_ok) begin
          sel_d   = deq_id;
          cnt_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (tlast_sel) begin
          cnt_d = cnt_q + CntW'(1);
          if (exhausted || max_hit || !en_in) begin
            turn_end = 1'b1;
            clr_sel  = !en_in;
          end else begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (tvalid_sel) begin
          state_d = StSend;
        end else begin
          turn_end = 1'b1;
          clr_sel  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (turn_end) begin
      state_d = StIdle;
      end_d   = sel_hot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      en_q    <= 1'b0;
      end_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= (state_d == StSend);
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      div_q   <= refill ? '0 : div_q + DivW'(1);
    end
  end

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_bucket
    pieo_token_bucket #(
      .PKT_LEN_WIDTH(PKT_LEN_WIDTH),
      .TB_SCALE     (TB_SCALE)
    ) u_tb (
      .clk      (clk),
      .rst_n    (rst_n),
      .shaping  (fifo_enable_shaping[i]),
      .refill   (refill),
      .grant    (grant[i]),
      .consume  (consume[i]),
      .clear    (clear[i]),
      .max_rate (fifo_max_rate[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH]),
      .quantum  (fifo_drr_quantum[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH]),
      .max_burst(fifo_max_burst[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH]),
      .pkt_len  (fifo_packet_length[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH]),
      .tb_next  (tb_next[i]),
      .eligible (tb_fifo_eligible[i])
    );
  end

  assign post_deq_ready = (state_q == StIdle);
  assign sel_out        = sel_q;
  assign en_out         = en_q;
  assign post_deq_end   = end_q;

endmodule

// File: tb/tb_pieo_post_deq_shaper.sv
// Scoreboarded bench: turn-end pulses are checked against queued expectations.
module tb_pieo_post_deq_shaper;
  localparam int P   = 16;
  localparam int NQ  = 6;
  localparam int IDL = 3;
  localparam int EW  = IDL + 2;

  logic clk = 1'b0, rst_n = 1'b0, en_in = 1'b0, dv_a = 1'b0, dv_b = 1'b0;
  logic [EW-1:0]   elem = '0;
  logic [NQ-1:0]   tvalid = '0, tlast = '0, shaping = '0;
  logic [NQ*P-1:0] plen = '0, quantum = '0, burst = '0, rate = '0;

  logic            ready_a, en_a, ready_b, en_b;
  logic [NQ-1:0]   elig_a, end_a, elig_b, end_b;
  logic [IDL-1:0]  sel_a, sel_b;

  always #5 clk = ~clk;

  pieo_post_deq_shaper #(.NUM_QUEUES(NQ), .ID_LOG(IDL), .MAX_PKTS(0)) ua (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .deq_valid(dv_a), .deq_element(elem),
    .post_deq_ready(ready_a), .fifo_tvalid(tvalid), .pe_tlast(tlast),
    .fifo_packet_length(plen), .fifo_drr_quantum(quantum), .fifo_max_burst(burst),
    .fifo_enable_shaping(shaping), .fifo_max_rate(rate), .tb_fifo_eligible(elig_a),
    .post_deq_end(end_a), .sel_out(sel_a), .en_out(en_a)
  );

  pieo_post_deq_shaper #(.NUM_QUEUES(NQ), .ID_LOG(IDL), .MAX_PKTS(2)) ub (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .deq_valid(dv_b), .deq_element(elem),
    .post_deq_ready(ready_b), .fifo_tvalid(tvalid), .pe_tlast(tlast),
    .fifo_packet_length(plen), .fifo_drr_quantum(quantum), .fifo_max_burst(burst),
    .fifo_enable_shaping(shaping), .fifo_max_rate(rate), .tb_fifo_eligible(elig_b),
    .post_deq_end(end_b), .sel_out(sel_b), .en_out(en_b)
  );

  logic signed [20:0] tb_a [NQ];
  logic signed [20:0] tb_b [NQ];
  for (genvar g = 0; g < NQ; g++) begin : g_peek
    assign tb_a[g] = ua.g_bucket[g].u_tb.tb_q;
    assign tb_b[g] = ub.g_bucket[g].u_tb.tb_q;
  end

  typedef struct {
    int                 inst;
    int                 q;
    logic [NQ-1:0]      endv;
    logic signed [20:0] tb;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: every cycle with a turn-end pulse consumes one expectation.
  exp_t               m_e;
  int                 m_inst;
  logic [NQ-1:0]      m_v;
  logic signed [20:0] m_t;
  always @(negedge clk) begin
    if (end_a != '0 || end_b != '0) begin
      m_inst = (end_a != '0) ? 0 : 1;
      m_v    = (m_inst == 0) ? end_a : end_b;
      if (sb.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_end: got inst %0d end %b want no pulse", m_inst, m_v);
      end else begin
        m_e = sb.pop_front();
        m_t = (m_inst == 0) ? tb_a[m_e.q] : tb_b[m_e.q];
        check("end_inst", m_inst, m_e.inst);
        check("end_vec", m_v, m_e.endv);
        check("end_tb", m_t, m_e.tb);
      end
    end
  end

  task automatic set_q(input int q, input int len, input int qu, input int bu, input int ra,
                       input bit sh);
    plen[q*P +: P]    = P'(len);
    quantum[q*P +: P] = P'(qu);
    burst[q*P +: P]   = P'(bu);
    rate[q*P +: P]    = P'(ra);
    shaping[q]        = sh;
  endtask

  task automatic expect_end(input int inst, input int q, input int tb_bytes);
    exp_t e;
    e.inst = inst;
    e.q    = q;
    e.endv = NQ'(1) << q;
    e.tb   = 21'(tb_bytes * 16);
    sb.push_back(e);
  endtask

  task automatic issue(input int inst, input int id);
    elem = EW'(id);
    check("ready_before_issue", (inst == 0) ? ready_a : ready_b, 1);
    if (inst == 0) dv_a = 1'b1;
    else dv_b = 1'b1;
    @(negedge clk);
    dv_a = 1'b0;
    dv_b = 1'b0;
  endtask

  // Plays the packet mux: one tlast per packet while en_out is high.
  task automatic serve(input int inst, input int q, input int npk, input bit drain);
    int t;
    for (int k = 0; k < npk; k++) begin
      t = 0;
      while (((inst == 0) ? en_a : en_b) !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        n_total++;
        n_bad++;
        $display("FAIL serve_timeout: got en_out 0 want 1 (inst %0d pkt %0d)", inst, k);
        return;
      end
      tlast[q] = 1'b1;
      if (drain && k == npk - 1) tvalid[q] = 1'b0;
      @(negedge clk);
      tlast[q] = 1'b0;
    end
  endtask

  task automatic drain_sb();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("pending_ends", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int q = 0; q < NQ; q++) set_q(q, 600, 1500, 65535, 0, 1'b0);
    set_q(1, 1500, 0, 2000, 100, 1'b1);
    en_in = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", ready_a, 1);
    check("rst_en_out", en_a, 0);
    check("rst_sel_out", sel_a, 0);
    check("rst_end", end_a, 0);

    // Release on a negedge so refill timing is exact: first tick after 16 edges.
    rst_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("ready_first_cycle", ready_a, 1);
        check("shaped_not_eligible", elig_a[1], 0);
        check("unshaped_eligible", elig_a[2], 1);
      end
      if (c == 15) check("tb_before_tick", tb_a[1], 0);
      if (c == 16) check("tb_first_tick", tb_a[1], 1600);
    end

    // Unshaped q2: 1500 quantum, three 600 B packets, deficit -300 kept.
    tvalid[2] = 1'b1;
    expect_end(0, 2, -300);
    issue(0, 2);
    serve(0, 2, 3, 1'b0);
    drain_sb();
    check("sel_holds_idle", sel_a, 2);
    check("en_low_after_turn", en_a, 0);

    // q3 empties after one packet: bucket cleared.
    tvalid[3] = 1'b1;
    expect_end(0, 3, 0);
    issue(0, 3);
    serve(0, 3, 1, 1'b1);
    drain_sb();

    // MAX_PKTS=2 instance, quantum 9000, 64 B packets.
    set_q(4, 64, 9000, 65535, 0, 1'b0);
    tvalid[4] = 1'b1;
    expect_end(1, 4, 9000 - 128);
    issue(1, 4);
    serve(1, 4, 2, 1'b0);
    drain_sb();
    repeat (3) @(negedge clk);
    check("maxpkts_en_low", en_b, 0);
    check("maxpkts_idle", ready_b, 1);

    // Out-of-range id is swallowed.
    issue(0, NQ);
    check("drop_ready", ready_a, 1);
    check("drop_en", en_a, 0);
    check("drop_sel", sel_a, 3);
    repeat (3) @(negedge clk);
    check("drop_en_later", en_a, 0);

    // Shaped q1 long since saturated at burst.
    repeat (400) @(negedge clk);
    check("shaped_saturated", tb_a[1], 2000 * 16);
    check("shaped_eligible_1500", elig_a[1], 1);
    plen[1*P +: P] = P'(2000);
    @(negedge clk);
    check("shaped_eligible_2000", elig_a[1], 1);
    plen[1*P +: P] = P'(2001);
    @(negedge clk);
    check("shaped_not_eligible_2001", elig_a[1], 0);

    // Reset mid-SEND: immediate abort, no pulse.
    tvalid[5] = 1'b1;
    issue(0, 5);
    check("send_en_high", en_a, 1);
    rst_n = 1'b0;
    #1;
    check("async_en_low", en_a, 0);
    check("async_ready", ready_a, 1);
    check("async_end", end_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", ready_a, 1);
    check("post_rst_tb5", tb_a[5], 0);
    check("post_rst_tb1", tb_a[1], 0);
    repeat (3) @(negedge clk);
    check("no_late_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
